// File: rtl/da_bitserial_mac.sv
// rtl/da_bitserial_mac.sv - bit-serial distributed-arithmetic dot-product engine
module da_bitserial_mac #(
  parameter int DATA_WIDTH_A = 16,
  parameter int DATA_WIDTH_B = 16,
  parameter int K            = 9,
  localparam int PS_WIDTH    = DATA_WIDTH_B + $clog2(K) + 1,
  localparam int OUT_WIDTH   = DATA_WIDTH_A + DATA_WIDTH_B + $clog2(K)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        signed_a,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH_A-1:0]     a_in [K],
  input  logic [DATA_WIDTH_B-1:0]     b_in [K],
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] y_out
);

  // Bit counter is at least one bit wide so DATA_WIDTH_A=1 still elaborates.
  localparam int CW = (DATA_WIDTH_A > 1) ? $clog2(DATA_WIDTH_A) : 1;
  localparam logic [CW-1:0] LAST_J = CW'(DATA_WIDTH_A - 1);
  // Odd K gets a zero partner for the last pair.
  localparam int NP = (K + 1) / 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_q, state_d;
  logic   accept;

  logic [DATA_WIDTH_A-1:0] a_q [K];
  logic [DATA_WIDTH_B-1:0] b_q [K];
  logic                    sa_q;
  logic [CW-1:0]           cnt_q;

  logic [DATA_WIDTH_A-1:0]    a_pad [2*NP];
  logic [DATA_WIDTH_B-1:0]    b_pad [2*NP];
  logic signed [PS_WIDTH-1:0] b0_ext, b1_ext, pair_sum, ps_sum;

  logic                        s1_valid;
  logic signed [PS_WIDTH-1:0]  s1_ps;
  logic [CW-1:0]               s1_j;
  logic signed [OUT_WIDTH-1:0] ps_ext, term, acc_q;

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt_q == LAST_J) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
    in_ready = (state_q == IDLE);
    accept   = (state_q == IDLE) && in_valid && !flush;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Operand capture at accept so the inputs are free to change during RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < K; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      sa_q <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < K; i++) begin
        a_q[i] <= a_in[i];
        b_q[i] <= b_in[i];
      end
      sa_q <= signed_a;
    end
  end

  // Bit-plane counter: restarts at accept, walks 0..DATA_WIDTH_A-1 during RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  cnt_q <= '0;
    else if (accept)                           cnt_q <= '0;
    else if (state_q == RUN && cnt_q != LAST_J) cnt_q <= cnt_q + 1'b1;
  end

  // Zero-padded operand view so every pair has two members.
  always_comb begin
    for (int i = 0; i < 2*NP; i++) begin
      a_pad[i] = '0;
      b_pad[i] = '0;
    end
    for (int i = 0; i < K; i++) begin
      a_pad[i] = a_q[i];
      b_pad[i] = b_q[i];
    end
  end

  // Pairwise 4-way select (0 / b0 / b1 / b0+b1) and sum of all pairs for plane cnt_q.
  always_comb begin
    ps_sum   = '0;
    b0_ext   = '0;
    b1_ext   = '0;
    pair_sum = '0;
    for (int p = 0; p < NP; p++) begin
      b0_ext = {{(PS_WIDTH-DATA_WIDTH_B){b_pad[2*p][DATA_WIDTH_B-1]}}, b_pad[2*p]};
      b1_ext = {{(PS_WIDTH-DATA_WIDTH_B){b_pad[2*p+1][DATA_WIDTH_B-1]}}, b_pad[2*p+1]};
      case ({a_pad[2*p+1][cnt_q], a_pad[2*p][cnt_q]})
        2'b01:   pair_sum = b0_ext;
        2'b10:   pair_sum = b1_ext;
        2'b11:   pair_sum = b0_ext + b1_ext;
        default: pair_sum = '0;
      endcase
      ps_sum = ps_sum + pair_sum;
    end
  end

  // Stage 1: register the plane's partial sum together with its bit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_ps    <= '0;
      s1_j     <= '0;
    end else begin
      s1_valid <= (state_q == RUN) && !flush;
      if (state_q == RUN) begin
        s1_ps <= ps_sum;
        s1_j  <= cnt_q;
      end
    end
  end

  // Weight the registered partial sum by 2^j; the sign plane of a signed A is negative.
  always_comb begin
    ps_ext = {{(OUT_WIDTH-PS_WIDTH){s1_ps[PS_WIDTH-1]}}, s1_ps};
    term   = ps_ext <<< s1_j;
  end

  // Stage 2 shift-accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                acc_q <= '0;
    else if (flush || accept) acc_q <= '0;
    else if (s1_valid) begin
      if (sa_q && s1_j == LAST_J) acc_q <= acc_q - term;
      else                        acc_q <= acc_q + term;
    end
  end

  // Result register: loaded once the accumulator has settled in DONE, held until taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      y_out     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (state_q == DONE) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        y_out     <= acc_q;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_da_bitserial_mac.sv
// tb/tb_da_bitserial_mac.sv - directed self-checking bench for da_bitserial_mac
module tb_da_bitserial_mac;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               signed_a;
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        a_in [9];
  logic [15:0]        b_in [9];
  logic               out_valid;
  logic               out_ready;
  logic signed [35:0] y_out;

  int total = 0;
  int bad   = 0;
  int n;

  da_bitserial_mac #(.DATA_WIDTH_A(16), .DATA_WIDTH_B(16), .K(9)) dut (
    .clk(clk), .rst(rst), .flush(flush), .signed_a(signed_a),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_vec(input logic [15:0] a, input logic [15:0] b, input bit b_ramp);
    for (int k = 0; k < 9; k++) begin
      a_in[k] = a;
      b_in[k] = b_ramp ? 16'(k + 1) : b;
    end
  endtask

  task automatic accept_vec(input bit sa);
    signed_a = sa;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input bit sa, input logic signed [63:0] exp, input string tag);
    int c;
    accept_vec(sa);
    chk({tag, "_busy"}, in_ready, 0);
    wait_valid(c);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_lat"}, c, 18);
    chk(tag, y_out, exp);
    take_out();
    chk({tag, "_idle"}, in_ready, 1);
    chk({tag, "_clr"}, out_valid, 0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; signed_a = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_vec(16'd0, 16'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y_out, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: unit A, ramp B
    set_vec(16'd1, 16'd0, 1'b1);
    run_vec(1'b1, 64'sd45, "t1");

    // 2: A=-1, B=1, signed and unsigned
    set_vec(16'hFFFF, 16'd1, 1'b0);
    run_vec(1'b1, -64'sd9, "t2s");
    run_vec(1'b0, 64'sd589815, "t2u");

    // 3: extreme operands
    set_vec(16'h8000, 16'h8000, 1'b0);
    run_vec(1'b1, 64'sd9663676416, "t3max");
    set_vec(16'h8000, 16'h7FFF, 1'b0);
    run_vec(1'b1, -64'sd9663381504, "t3min");

    // 4: back-pressure with ignored in_valid pulses; operands changed after accept
    set_vec(16'd1, 16'd0, 1'b1);
    accept_vec(1'b1);
    set_vec(16'h1234, 16'h4321, 1'b0);
    wait_valid(n);
    chk("t4_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      @(posedge clk); #1;
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_y", y_out, 45);
      chk("t4_hold_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    take_out();
    chk("t4_idle", in_ready, 1);
    chk("t4_clr", out_valid, 0);

    // 5: flush at bit 7 with in_valid high
    set_vec(16'd1, 16'd0, 1'b1);
    accept_vec(1'b1);
    repeat (7) @(posedge clk);
    #1;
    chk("t5_running", in_ready, 0);
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_idle", in_ready, 1);
    chk("t5_novalid", out_valid, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("t5_still_idle", in_ready, 1);
    chk("t5_still_novalid", out_valid, 0);
    run_vec(1'b1, 64'sd45, "t5_next");

    // 6: asynchronous reset mid-RUN
    set_vec(16'hFFFF, 16'd1, 1'b0);
    accept_vec(1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_in_ready", in_ready, 1);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_y", y_out, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    set_vec(16'd1, 16'd0, 1'b1);
    run_vec(1'b1, 64'sd45, "t6_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
